logic2048_move_ctrl: RTL and testbench
======================================

Name: logic2048_move_ctrl

Overview:
- Sequences one full 2048 board move: holds the 4x4 board, feeds one line per cycle through a single shared single-line merge datapath for the commanded direction, and writes the result back.
- After a move that changes the board, spawns a new tile at a pseudo-random empty cell, then evaluates win and game-over.
- Sits between the key/command front end and the display/board readout.

Parameters:
- SEED, 16'hACE1, non-zero LFSR reset value.
- WIN_LEVEL, 11, tile exponent that sets win (11 = 2048).
- SPAWN_EN, 1, 0 disables tile spawning (bench determinism).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  load board_load into the board (accepted only in IDLE).
- board_load  in  64  cell (r,c) at [(4r+c)*4 +: 4], exponent, 0 = empty.
- cmd_valid  in  1  move request.
- cmd_dir  in  2  0=left, 1=right, 2=up, 3=down.
- cmd_ready  out  1  = (state==IDLE) && !load_valid.
- board  out  64  current board, same packing.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at the end of a move.
- moved  out  1  valid with done: board changed by the slide/merge.
- win  out  1  sticky until load: any cell >= WIN_LEVEL.
- game_over  out  1  no empty cell and no equal orthogonal neighbours.

Behaviour:
- Reset (async, rst_n low):
  - board=0, state=IDLE, lfsr=SEED, line index=0.
  - done, moved, win, game_over all 0.
  - Reset mid-move aborts the move; the partial board is discarded.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle out of reset.
- Load:
  - In IDLE with load_valid: board<=board_load, win cleared and then recomputed, game_over recomputed next cycle.
  - load_valid outside IDLE is ignored.
  - load_valid and cmd_valid in the same cycle: load wins; the command is not accepted.
- FSM states: IDLE, LINE, SPAWN, CHECK, DONE.
- IDLE -> LINE on cmd_valid && cmd_ready. Latch cmd_dir; i=0; moved_acc=0.
- LINE (exactly 4 cycles, i=0..3):
  - Line i is extracted as x0..x3, with x0 the destination edge:
    - left: (i,0),(i,1),(i,2),(i,3)
    - right: (i,3),(i,2),(i,1),(i,0)
    - up: (0,i),(1,i),(2,i),(3,i)
    - down: (3,i),(2,i),(1,i),(0,i)
  - y0..y3 are written back to the same cells at the clock edge.
  - All-zero line: the controller forces y=0 and does not use the datapath outputs (the datapath holds its outputs for this input).
  - Line changed = (y != x); the datapath movable output is not used.
  - moved_acc |= line changed.
  - Merged tile of 15 wraps to 0 (4-bit); this is not guarded, because win fires at WIN_LEVEL first.
  - After i=3: go to SPAWN if moved_acc && SPAWN_EN, else CHECK.
- SPAWN:
  - Scan pointer starts at lfsr[3:0] on entry and increments mod 16, one cell per cycle.
  - First empty cell gets 2 if lfsr[7:4]==0, else 1. Then go to CHECK.
  - Scan is bounded to 16 cycles; with no empty cell found, go to CHECK with no write (unreachable when moved=1).
- CHECK (1 cycle): register game_over; set win if any cell >= WIN_LEVEL.
- DONE (1 cycle): done=1, moved=moved_acc; return to IDLE.
- Latency from accept to done:
  - 6 cycles when not moved or SPAWN_EN=0.
  - 7..22 cycles with spawn.
- cmd_valid while busy is ignored; it is not queued.

Decomposition:
- Shared package logic2048_pkg:
  - direction encoding constants DIR_LEFT/RIGHT/UP/DOWN
  - cell width 4
  - board packing index function cell_idx(r,c)
  - FSM state enum
  - LFSR tap constant
- One sub-module: instantiate the existing single-line merge block (logic2048SingleLine) once, combinationally, driven by the line mux.
- Line extract/scatter mux and the game_over evaluator stay in this module.

Test Plan:
- SPAWN_EN=0; load row0=[1,1,2,2], rest 0; cmd left -> row0=[2,3,0,0]; done at cycle 6 after accept; moved=1.
- SPAWN_EN=0; load row0=[1,2,3,4], rest 0; cmd left -> board unchanged, moved=0. Then cmd right -> row0=[0,1,2,3]... is wrong: with no equal pairs, right slides nothing; required result is row0 unchanged, moved=0. Then load column0=[0,0,0,1], cmd up -> (0,0)=1, moved=1.
- SPAWN_EN=1, SEED default; load (3,3)=1; cmd left:
  - exactly one new cell in {1,2}; cell count=2.
  - done within 22 cycles of accept.
  - the same seed and cycle timing reproduce the same cell.
- Load checkerboard of 1/2 (full, no equal neighbours) -> game_over=1 after load. Cmd in any direction -> moved=0, board unchanged.
- SPAWN_EN=0; load row0=[10,10,0,0]; cmd left -> (0,0)=11, win=1, sticky through the next move, cleared by load.
- Assert rst_n low during LINE i=2 -> board=0, busy=0, done never pulses. cmd_valid+load_valid in the same IDLE cycle -> load applied, no move.

Source files
------------

// File: rtl/logic2048_pkg.sv
// Shared definitions for the 2048 move controller: encodings, FSM states,
// board packing helpers and the spawn LFSR taps.
package logic2048_pkg;

    localparam int CELL_W = 4;

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LINE,
        ST_SPAWN,
        ST_CHECK,
        ST_DONE
    } state_t;

    function automatic logic [3:0] cell_idx(input logic [1:0] r, input logic [1:0] c);
        return {r, c};
    endfunction

    // Cell holding element k of line i, with k=0 at the edge tiles slide toward.
    function automatic logic [3:0] line_cell(input logic [1:0] dir, input logic [1:0] i,
                                             input logic [1:0] k);
        logic [3:0] idx;
        case (dir)
            DIR_LEFT:  idx = cell_idx(i, k);
            DIR_RIGHT: idx = cell_idx(i, 2'd3 - k);
            DIR_UP:    idx = cell_idx(k, i);
            default:   idx = cell_idx(2'd3 - k, i);
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/logic2048SingleLine.sv
// Combinational single-line slide/merge toward element 0; each tile merges
// at most once per move, merged value is exponent+1 (4-bit wrap).
module logic2048SingleLine (
    input  logic [15:0] x,
    output logic [15:0] y,
    output logic        movable
);
    logic [19:0] c;
    logic [1:0]  n;
    logic [1:0]  k;
    logic        skip;

    always_comb begin
        c = '0;
        n = '0;
        for (int j = 0; j < 4; j++) begin
            if (x[j*4 +: 4] != 4'd0) begin
                c[{n, 2'b00} +: 4] = x[j*4 +: 4];
                n = n + 2'd1;
            end
        end

        // c[19:16] stays zero so the last pair compare never matches.
        y    = '0;
        k    = '0;
        skip = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (c[j*4 +: 4] != 4'd0) begin
                if (c[j*4 +: 4] == c[j*4+4 +: 4]) begin
                    y[{k, 2'b00} +: 4] = c[j*4 +: 4] + 4'd1;
                    skip = 1'b1;
                end else begin
                    y[{k, 2'b00} +: 4] = c[j*4 +: 4];
                end
                k = k + 2'd1;
            end
        end
    end

    assign movable = (y != x);

endmodule

// File: rtl/logic2048_move_ctrl.sv
// 2048 move sequencer: one line per cycle through a shared merge datapath,
// optional random tile spawn, then win/game-over evaluation.
module logic2048_move_ctrl
    import logic2048_pkg::*;
#(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          WIN_LEVEL = 11,
    parameter int          SPAWN_EN  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic [63:0] board_load,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_dir,
    output logic        cmd_ready,
    output logic [63:0] board,
    output logic        busy,
    output logic        done,
    output logic        moved,
    output logic        win,
    output logic        game_over
);
    localparam logic [4:0] WIN_L = 5'(WIN_LEVEL);

    state_t      state, state_n;
    logic [1:0]  dir, line_i;
    logic        moved_acc, win_q, game_over_q, chk_pend;
    logic [3:0]  ptr, scan_cnt;
    logic [15:0] lfsr;
    logic [63:0] board_q, board_line;
    logic [15:0] x, y_dp, y;
    logic        line_changed, cell_empty, any_win, no_moves, accept;
    logic [3:0]  spawn_val;
    logic        dp_movable_unused;

    logic2048SingleLine u_line (
        .x       (x),
        .y       (y_dp),
        .movable (dp_movable_unused)
    );

    always_comb begin
        x = '0;
        for (int k = 0; k < 4; k++)
            x[k*4 +: 4] = board_q[{line_cell(dir, line_i, 2'(k)), 2'b00} +: 4];
    end

    // Empty lines bypass the datapath; change detection compares y against x.
    assign y            = (x == 16'd0) ? 16'd0 : y_dp;
    assign line_changed = (y != x);

    always_comb begin
        board_line = board_q;
        for (int k = 0; k < 4; k++)
            board_line[{line_cell(dir, line_i, 2'(k)), 2'b00} +: 4] = y[k*4 +: 4];
    end

    assign cell_empty = (board_q[{ptr, 2'b00} +: 4] == 4'd0);
    assign spawn_val  = (lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;

    always_comb begin
        any_win  = 1'b0;
        no_moves = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if ({1'b0, board_q[i*4 +: 4]} >= WIN_L) any_win = 1'b1;
            if (board_q[i*4 +: 4] == 4'd0) no_moves = 1'b0;
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (board_q[(r*4+c)*4 +: 4] == board_q[(r*4+c+1)*4 +: 4]) no_moves = 1'b0;
                if (board_q[(c*4+r)*4 +: 4] == board_q[((c+1)*4+r)*4 +: 4]) no_moves = 1'b0;
            end
        end
    end

    assign cmd_ready = (state == ST_IDLE) && !load_valid;
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (accept) state_n = ST_LINE;
            ST_LINE:  if (line_i == 2'd3)
                          state_n = ((moved_acc || line_changed) && (SPAWN_EN != 0)) ? ST_SPAWN : ST_CHECK;
            ST_SPAWN: if (cell_empty || scan_cnt == 4'd15) state_n = ST_CHECK;
            ST_CHECK: state_n = ST_DONE;
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board_q     <= '0;
            lfsr        <= SEED;
            dir         <= DIR_LEFT;
            line_i      <= '0;
            moved_acc   <= 1'b0;
            ptr         <= '0;
            scan_cnt    <= '0;
            win_q       <= 1'b0;
            game_over_q <= 1'b0;
            chk_pend    <= 1'b0;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};

            // Deferred evaluation one cycle after a load; overridden below if
            // another load arrives in the same cycle.
            if (chk_pend) begin
                win_q       <= win_q | any_win;
                game_over_q <= no_moves;
                chk_pend    <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (load_valid) begin
                        board_q  <= board_load;
                        win_q    <= 1'b0;
                        chk_pend <= 1'b1;
                    end else if (cmd_valid) begin
                        dir       <= cmd_dir;
                        line_i    <= '0;
                        moved_acc <= 1'b0;
                    end
                end
                ST_LINE: begin
                    board_q   <= board_line;
                    moved_acc <= moved_acc | line_changed;
                    line_i    <= line_i + 2'd1;
                    ptr       <= lfsr[3:0];
                    scan_cnt  <= '0;
                end
                ST_SPAWN: begin
                    if (cell_empty) begin
                        board_q[{ptr, 2'b00} +: 4] <= spawn_val;
                    end else begin
                        ptr      <= ptr + 4'd1;
                        scan_cnt <= scan_cnt + 4'd1;
                    end
                end
                ST_CHECK: begin
                    win_q       <= win_q | any_win;
                    game_over_q <= no_moves;
                end
                default: ;
            endcase
        end
    end

    assign board     = board_q;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign moved     = (state == ST_DONE) && moved_acc;
    assign win       = win_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_logic2048_move_ctrl.sv
// Scoreboard bench: dut0 runs without spawning (exact boards), dut1 spawns
// and is checked against an independent LFSR model.
module tb_logic2048_move_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [63:0] board_load = '0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_dir = 2'd0;

    logic        cmd_ready0, busy0, done0, moved0, win0, go0;
    logic        cmd_ready1, busy1, done1, moved1, win1, go1;
    logic [63:0] board0, board1;

    logic2048_move_ctrl #(.SPAWN_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .board_load(board_load),
        .cmd_valid(cmd_valid), .cmd_dir(cmd_dir), .cmd_ready(cmd_ready0), .board(board0),
        .busy(busy0), .done(done0), .moved(moved0), .win(win0), .game_over(go0));

    logic2048_move_ctrl #(.SPAWN_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .board_load(board_load),
        .cmd_valid(cmd_valid), .cmd_dir(cmd_dir), .cmd_ready(cmd_ready1), .board(board1),
        .busy(busy1), .done(done1), .moved(moved1), .win(win1), .game_over(go1));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [63:0] board;
        logic        moved;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    function automatic logic [15:0] step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    logic [15:0] m;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) m <= 16'hACE1;
        else        m <= step(m);

    function automatic logic [63:0] put(input logic [63:0] b, input int r, input int c,
                                        input logic [3:0] v);
        b[(r*4+c)*4 +: 4] = v;
        return b;
    endfunction

    function automatic logic [63:0] row0(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] c, input logic [3:0] d);
        return {48'd0, d, c, b, a};
    endfunction

    task automatic push_exp(input logic [63:0] b, input logic mv, input int lat);
        exp_t e;
        e.board = b; e.moved = mv; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; load_valid = 1'b0; cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [63:0] b);
        @(negedge clk);
        load_valid = 1'b1; board_load = b;
        @(negedge clk);
        load_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_move(input logic [1:0] d, output logic [15:0] ms);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dir = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        ms = m;
    endtask

    // Latency counts the accept cycle as 0; the DONE cycle index is reported.
    task automatic finish_move(input bit sel, input string name);
        exp_t e;
        int lat;
        logic seen, mv;
        logic [63:0] b;
        seen = 1'b0; lat = 0; mv = 1'b0; b = '0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (!seen && (sel ? done1 : done0)) begin
                seen = 1'b1; lat = k + 1;
                b  = sel ? board1 : board0;
                mv = sel ? moved1 : moved0;
            end
        end
        e = exp_q.pop_front();
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_done: no done within 30 cycles", name);
        end else begin
            n_chk += 3;
            if (b !== e.board) begin
                n_fail++; $display("FAIL %s_board: got %h want %h", name, b, e.board);
            end
            if (mv !== e.moved) begin
                n_fail++; $display("FAIL %s_moved: got %b want %b", name, mv, e.moved);
            end
            if (lat != e.lat) begin
                n_fail++; $display("FAIL %s_latency: got %0d want %0d", name, lat, e.lat);
            end
        end
    endtask

    task automatic test_reset;
        do_reset();
        n_chk++;
        if ({board0, board1} !== 128'd0) begin
            n_fail++; $display("FAIL reset_board: got %h %h want 0", board0, board1);
        end
        n_chk++;
        if ({busy0, done0, moved0, win0, go0, cmd_ready0} !== 6'b000001) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000001",
                               {busy0, done0, moved0, win0, go0, cmd_ready0});
        end
    endtask

    task automatic test_merge;
        logic [15:0] ms;
        load(row0(1, 1, 2, 2));
        push_exp(row0(2, 3, 0, 0), 1'b1, 6);
        start_move(2'd0, ms);
        finish_move(1'b0, "merge_left");
    endtask

    task automatic test_no_move;
        logic [15:0] ms;
        load(row0(1, 2, 3, 4));
        push_exp(row0(1, 2, 3, 4), 1'b0, 6);
        start_move(2'd0, ms);
        finish_move(1'b0, "nomove_left");
        push_exp(row0(1, 2, 3, 4), 1'b0, 6);
        start_move(2'd1, ms);
        finish_move(1'b0, "nomove_right");
        load(put(64'd0, 3, 0, 4'd1));
        push_exp(put(64'd0, 0, 0, 4'd1), 1'b1, 6);
        start_move(2'd2, ms);
        finish_move(1'b0, "slide_up");
    endtask

    task automatic test_spawn;
        logic [15:0] ms, s3, s4, s5;
        logic [63:0] bm, eb, first;
        int p, cnt, lat;
        logic [3:0] v, nv;
        first = '0;
        for (int rep = 0; rep < 2; rep++) begin
            do_reset();
            repeat (3) @(negedge clk);
            load(put(64'd0, 3, 3, 4'd1));
            start_move(2'd0, ms);
            s3 = step(step(step(ms)));
            s4 = step(s3);
            s5 = step(s4);
            p  = int'(s3[3:0]);
            bm = put(64'd0, 3, 0, 4'd1);
            if (p != 12) begin
                eb  = put(bm, p / 4, p % 4, (s4[7:4] == 4'd0) ? 4'd2 : 4'd1);
                lat = 7;
            end else begin
                eb  = put(bm, 3, 1, (s5[7:4] == 4'd0) ? 4'd2 : 4'd1);
                lat = 8;
            end
            push_exp(eb, 1'b1, lat);
            finish_move(1'b1, "spawn");
            cnt = 0; nv = 4'd0;
            for (int i = 0; i < 16; i++) begin
                v = board1[i*4 +: 4];
                if (v != 4'd0) cnt++;
                if (i != 12 && v != 4'd0) nv = v;
            end
            n_chk++;
            if (cnt != 2 || !(nv == 4'd1 || nv == 4'd2)) begin
                n_fail++; $display("FAIL spawn_cells: got count %0d tile %0d want 2 and 1..2", cnt, nv);
            end
            if (rep == 0) begin
                first = board1;
            end else begin
                n_chk++;
                if (board1 !== first) begin
                    n_fail++; $display("FAIL spawn_repeat: got %h want %h", board1, first);
                end
            end
        end
    endtask

    task automatic test_game_over;
        logic [63:0] cb;
        logic [15:0] ms;
        cb = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                cb = put(cb, r, c, ((r + c) % 2 != 0) ? 4'd2 : 4'd1);
        load(cb);
        n_chk++;
        if ({go0, go1} !== 2'b11) begin
            n_fail++; $display("FAIL game_over_load: got %b want 11", {go0, go1});
        end
        push_exp(cb, 1'b0, 6);
        start_move(2'd0, ms);
        finish_move(1'b0, "go_left");
        push_exp(cb, 1'b0, 6);
        start_move(2'd3, ms);
        finish_move(1'b1, "go_down");
        n_chk++;
        if (go1 !== 1'b1) begin
            n_fail++; $display("FAIL game_over_after_move: got %b want 1", go1);
        end
    endtask

    task automatic test_win;
        logic [15:0] ms;
        load(row0(10, 10, 0, 0));
        n_chk++;
        if (win0 !== 1'b0) begin
            n_fail++; $display("FAIL win_before: got %b want 0", win0);
        end
        push_exp(row0(11, 0, 0, 0), 1'b1, 6);
        start_move(2'd0, ms);
        finish_move(1'b0, "win_left");
        n_chk++;
        if (win0 !== 1'b1) begin
            n_fail++; $display("FAIL win_set: got %b want 1", win0);
        end
        push_exp(row0(0, 0, 0, 11), 1'b1, 6);
        start_move(2'd1, ms);
        finish_move(1'b0, "win_right");
        n_chk++;
        if (win0 !== 1'b1) begin
            n_fail++; $display("FAIL win_sticky: got %b want 1", win0);
        end
        load(row0(1, 0, 0, 0));
        n_chk++;
        if (win0 !== 1'b0) begin
            n_fail++; $display("FAIL win_clear: got %b want 0", win0);
        end
    endtask

    task automatic test_reset_mid_move;
        logic [15:0] ms;
        logic pulsed;
        load(row0(1, 1, 0, 0));
        start_move(2'd0, ms);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (board0 !== 64'd0 || busy0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_move: got board %h busy %b want 0 0", board0, busy0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulsed = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done0) pulsed = 1'b1;
        end
        n_chk++;
        if (pulsed !== 1'b0 || board0 !== 64'd0) begin
            n_fail++; $display("FAIL reset_abort: got done %b board %h want 0 0", pulsed, board0);
        end
    endtask

    task automatic test_load_and_cmd;
        logic [63:0] b;
        logic pulsed;
        b = row0(1, 1, 0, 0);
        @(negedge clk);
        load_valid = 1'b1; board_load = b; cmd_valid = 1'b1; cmd_dir = 2'd0;
        #1;
        n_chk++;
        if (cmd_ready0 !== 1'b0) begin
            n_fail++; $display("FAIL load_cmd_ready: got %b want 0", cmd_ready0);
        end
        @(negedge clk);
        load_valid = 1'b0; cmd_valid = 1'b0;
        n_chk++;
        if (busy0 !== 1'b0 || board0 !== b) begin
            n_fail++; $display("FAIL load_cmd_apply: got busy %b board %h want 0 %h", busy0, board0, b);
        end
        pulsed = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done0 || busy0) pulsed = 1'b1;
        end
        n_chk++;
        if (pulsed !== 1'b0 || board0 !== b) begin
            n_fail++; $display("FAIL load_cmd_nomove: got activity %b board %h want 0 %h", pulsed, board0, b);
        end
    endtask

    initial begin
        test_reset();
        test_merge();
        test_no_move();
        test_spawn();
        test_game_over();
        test_win();
        test_reset_mid_move();
        test_load_and_cmd();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
